// File: rtl/evb_pkg.sv
// rtl/evb_pkg.sv - shared types, constants and helpers for the event-frame reader
package evb_pkg;

  typedef enum logic [2:0] {
    T_EV_HDR  = 3'd0,
    T_TIME_HI = 3'd1,
    T_TIME_LO = 3'd2,
    T_CH_DATA = 3'd3,
    T_CH_TRL  = 3'd4,
    T_MOD_TRL = 3'd5,
    T_FILLER  = 3'd6,
    T_RSVD    = 3'd7
  } word_type_e;

  typedef enum logic [2:0] {
    S_IDLE, S_EV_HDR, S_TIME_HI, S_TIME_LO, S_CH, S_MOD_TRL, S_FILLER, S_RESYNC
  } state_e;

  localparam int         MAX_CH_WORDS_DEF = 134;
  localparam int         CNT_W            = 12;
  localparam logic [1:0] CH_TRL_MARK      = 2'b11;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/evb_out_stage.sv
// rtl/evb_out_stage.sv - one-entry valid/ready output register
module evb_out_stage (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic        ready,
  output logic        space,
  output logic        valid,
  output logic [31:0] data
);

  // Space also covers the slot being vacated this cycle, giving full throughput.
  assign space = !valid || ready;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/evb_frame_reader.sv
// rtl/evb_frame_reader.sv - pops, checks and type-tags event frames from the builder FIFO
module evb_frame_reader
  import evb_pkg::*;
#(
  parameter int MAX_CH_WORDS = MAX_CH_WORDS_DEF
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        ALL_CLEAR,
  input  logic        ENABLE,
  input  logic [15:0] ENABLE_MASK,
  input  logic [11:0] MODULE_ID,
  input  logic [23:0] FIFO_DATA,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RD,
  output logic [31:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        EVENT_DONE,
  output logic [23:0] EV_READ_CNT,
  output logic [4:0]  ERR_FLAGS
);

  state_e           state, state_nx;
  word_type_e       wtype;
  logic [15:0]      mask_q;
  logic [4:0]       n_ch, trl_cnt;
  logic [CNT_W-1:0] ch_words, ch_run;
  logic [23:0]      prev_ev;
  logic             have_prev;
  logic             space, consume, load, frame_end;
  logic             is_trl, at_limit, ch_close;

  assign n_ch     = popcount16(mask_q);
  assign is_trl   = FIFO_DATA[20:19] == CH_TRL_MARK;
  assign at_limit = ch_run == CNT_W'(MAX_CH_WORDS - 1);
  assign ch_close = is_trl || at_limit;

  // Resync drops words without touching the output register, so it ignores backpressure.
  assign consume   = !FIFO_EMPTY && !ALL_CLEAR && (state != S_IDLE) &&
                     (space || state == S_RESYNC);
  assign load      = consume && (state != S_RESYNC);
  assign FIFO_RD   = consume;
  assign frame_end = consume && (FIFO_DATA == '0) &&
                     (state == S_FILLER || state == S_RESYNC);

  always_comb begin
    state_nx = state;
    wtype    = T_RSVD;
    case (state)
      S_IDLE:    if (ENABLE && !FIFO_EMPTY) state_nx = S_EV_HDR;
      S_EV_HDR:  begin wtype = T_EV_HDR;  if (consume) state_nx = S_TIME_HI; end
      S_TIME_HI: begin wtype = T_TIME_HI; if (consume) state_nx = S_TIME_LO; end
      S_TIME_LO: begin
        wtype = T_TIME_LO;
        if (consume) state_nx = (mask_q == '0) ? S_MOD_TRL : S_CH;
      end
      S_CH: begin
        wtype = ch_close ? T_CH_TRL : T_CH_DATA;
        if (consume && ch_close && (trl_cnt + 5'd1 == n_ch)) state_nx = S_MOD_TRL;
      end
      S_MOD_TRL: begin wtype = T_MOD_TRL; if (consume) state_nx = S_FILLER; end
      S_FILLER: begin
        wtype = T_FILLER;
        if (consume) state_nx = (FIFO_DATA == '0) ? S_IDLE : S_RESYNC;
      end
      S_RESYNC:  if (consume && FIFO_DATA == '0) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      trl_cnt     <= '0;
      ch_words    <= '0;
      ch_run      <= '0;
      prev_ev     <= '0;
      have_prev   <= 1'b0;
      ERR_FLAGS   <= '0;
      EV_READ_CNT <= '0;
      EVENT_DONE  <= 1'b0;
    end else if (ALL_CLEAR) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      trl_cnt     <= '0;
      ch_words    <= '0;
      ch_run      <= '0;
      prev_ev     <= '0;
      have_prev   <= 1'b0;
      ERR_FLAGS   <= '0;
      EV_READ_CNT <= '0;
      EVENT_DONE  <= 1'b0;
    end else begin
      state      <= state_nx;
      EVENT_DONE <= frame_end;
      if (frame_end) EV_READ_CNT <= EV_READ_CNT + 24'd1;
      if (consume) begin
        case (state)
          S_EV_HDR: begin
            mask_q   <= ENABLE_MASK;
            trl_cnt  <= '0;
            ch_words <= '0;
            ch_run   <= '0;
            if (have_prev && FIFO_DATA != prev_ev + 24'd1) ERR_FLAGS[0] <= 1'b1;
            prev_ev   <= FIFO_DATA;
            have_prev <= 1'b1;
          end
          S_CH: begin
            ch_words <= ch_words + 1'b1;
            if (ch_close) begin
              trl_cnt <= trl_cnt + 5'd1;
              ch_run  <= '0;
              if (!is_trl) ERR_FLAGS[3] <= 1'b1;
            end else begin
              ch_run <= ch_run + 1'b1;
            end
          end
          S_MOD_TRL: begin
            if (FIFO_DATA[23:12] != MODULE_ID) ERR_FLAGS[1] <= 1'b1;
            if (FIFO_DATA[11:0] != ch_words)   ERR_FLAGS[2] <= 1'b1;
          end
          S_FILLER: if (FIFO_DATA != '0) ERR_FLAGS[4] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  evb_out_stage u_out (
    .CLK     (CLK),
    .RSTb    (RSTb),
    .clr     (ALL_CLEAR),
    .load    (load),
    .data_in ({wtype, 5'b0, FIFO_DATA}),
    .ready   (OUT_READY),
    .space   (space),
    .valid   (OUT_VALID),
    .data    (OUT_DATA)
  );

endmodule

// File: tb/tb_evb_frame_reader.sv
// tb/tb_evb_frame_reader.sv - scoreboard bench with a frame-level reference model
module tb_evb_frame_reader;

  localparam int MAX_CH = 134;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        ALL_CLEAR = 1'b0;
  logic        ENABLE = 1'b1;
  logic [15:0] ENABLE_MASK = '0;
  logic [11:0] MODULE_ID = 12'h0AC;
  logic [23:0] FIFO_DATA = '0;
  logic        FIFO_EMPTY = 1'b1;
  logic        FIFO_RD;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic        EVENT_DONE;
  logic [23:0] EV_READ_CNT;
  logic [4:0]  ERR_FLAGS;

  evb_frame_reader dut (
    .CLK(CLK), .RSTb(RSTb), .ALL_CLEAR(ALL_CLEAR), .ENABLE(ENABLE),
    .ENABLE_MASK(ENABLE_MASK), .MODULE_ID(MODULE_ID), .FIFO_DATA(FIFO_DATA),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD(FIFO_RD), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .EVENT_DONE(EVENT_DONE),
    .EV_READ_CNT(EV_READ_CNT), .ERR_FLAGS(ERR_FLAGS)
  );

  always #5 CLK = ~CLK;

  logic [23:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0, n_pass = 0;
  int          done_seen = 0, exp_done = 0;
  logic [23:0] exp_cnt = '0;
  logic [4:0]  exp_flags = '0;
  logic [23:0] prev_ev = '0;
  bit          have_prev = 0;
  bit          rand_mode = 0;
  bit          pop_pending = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  int          ch_len[16];
  bit          ch_no_trl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic push(input logic [23:0] w, input logic [2:0] t, input bit fwd);
    fifo_q.push_back(w);
    if (fwd) exp_q.push_back({t, 5'b0, w});
  endtask

  // Builds one frame from its description and records what the reader must emit.
  task automatic send_frame(input logic [23:0] ev, input logic [47:0] tm, input logic [15:0] mask,
                            input logic [11:0] modid, input int cnt_adj,
                            input logic [23:0] filler, input int n_junk);
    int total;
    logic [23:0] d;
    logic [11:0] cw;
    total = 0;
    ENABLE_MASK = mask;
    if (have_prev && ev != prev_ev + 24'd1) exp_flags[0] = 1'b1;
    have_prev = 1;
    prev_ev = ev;
    push(ev, 3'd0, 1);
    push(tm[47:24], 3'd1, 1);
    push(tm[23:0], 3'd2, 1);
    for (int c = 0; c < 16; c++) begin
      if (mask[c]) begin
        for (int i = 0; i < ch_len[c]; i++) begin
          d = 24'($urandom);
          if (i == ch_len[c] - 1 && !ch_no_trl[c]) begin
            d[20:19] = 2'b11;
            push(d, 3'd4, 1);
          end else begin
            d[20] = 1'b0;
            if (i == MAX_CH - 1) begin
              push(d, 3'd4, 1);
              exp_flags[3] = 1'b1;
            end else push(d, 3'd3, 1);
          end
        end
        total += ch_len[c];
      end
    end
    cw = 12'(total + cnt_adj);
    push({modid, cw}, 3'd5, 1);
    if (modid != MODULE_ID) exp_flags[1] = 1'b1;
    if (cw != 12'(total)) exp_flags[2] = 1'b1;
    push(filler, 3'd6, 1);
    if (filler != '0) begin
      exp_flags[4] = 1'b1;
      for (int j = 0; j < n_junk; j++) push(24'($urandom) | 24'h1, 3'd0, 0);
      push(24'h0, 3'd0, 0);
    end
    exp_cnt = exp_cnt + 24'd1;
    exp_done++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
      @(posedge CLK);
      n++;
    end
    chk("drain_timeout", 32'(n < 20000), 32'd1);
    repeat (4) @(posedge CLK);
  endtask

  task automatic check_state(input string tag);
    @(negedge CLK);
    chk({tag, "_cnt"}, 32'(EV_READ_CNT), 32'(exp_cnt));
    chk({tag, "_flags"}, 32'(ERR_FLAGS), 32'(exp_flags));
    chk({tag, "_done"}, done_seen, exp_done);
  endtask

  task automatic do_clear();
    @(posedge CLK);
    #1 ALL_CLEAR = 1'b1;
    @(posedge CLK);
    #1 ALL_CLEAR = 1'b0;
    exp_flags = '0;
    exp_cnt = '0;
    have_prev = 0;
    check_state("clear");
  endtask

  task automatic set_channels(input int len0, input int len1, input int len2);
    for (int c = 0; c < 16; c++) begin
      ch_len[c] = 1;
      ch_no_trl[c] = 0;
    end
    ch_len[0] = len0;
    ch_len[1] = len1;
    ch_len[2] = len2;
  endtask

  // FIFO model: show-ahead head word, optional empty gaps, random downstream stalls.
  initial forever begin
    @(posedge CLK);
    if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
    FIFO_EMPTY = (rand_mode && $urandom_range(0, 3) == 0) || fifo_q.size() == 0;
    FIFO_DATA  = (fifo_q.size() != 0) ? fifo_q[0] : 24'h0;
    OUT_READY  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge CLK);
    if (!RSTb) begin
      pop_pending = 0;
      prev_stall = 0;
    end else begin
      pop_pending = FIFO_RD;
      if (FIFO_RD) chk("rd_while_empty", 32'(FIFO_EMPTY), 32'd0);
      if (prev_stall) begin
        chk("stall_valid", 32'(OUT_VALID), 32'd1);
        chk("stall_data", OUT_DATA, prev_data);
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data = OUT_DATA;
      if (EVENT_DONE) done_seen++;
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_extra: got %h, required no word", OUT_DATA);
        end else begin
          chk("out_word", OUT_DATA, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [23:0] ev;
    logic [15:0] m;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_fifo_rd", 32'(FIFO_RD), 32'd0);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_out_data", OUT_DATA, 32'd0);
    chk("rst_event_done", 32'(EVENT_DONE), 32'd0);
    chk("rst_ev_cnt", 32'(EV_READ_CNT), 32'd0);
    chk("rst_err_flags", 32'(ERR_FLAGS), 32'd0);
    @(posedge CLK);
    #1 RSTb = 1'b1;
    rand_mode = 1;

    set_channels(3, 1, 1);
    send_frame(24'd5, 48'h000001_000002, 16'h0003, 12'h0AC, 0, 24'h0, 0);
    wait_drain();
    check_state("basic");

    do_clear();
    set_channels(2, 4, 1);
    send_frame(24'd7, 48'h123456_789ABC, 16'h0003, 12'h0AC, 0, 24'h0, 0);
    send_frame(24'd9, 48'h000000_000010, 16'h0003, 12'h0AC, 0, 24'h0, 0);
    wait_drain();
    check_state("seq");

    do_clear();
    set_channels(2, 1, 3);
    send_frame(24'd20, 48'h0, 16'h0005, 12'h0AB, 1, 24'h0, 0);
    wait_drain();
    check_state("modid_count");

    do_clear();
    set_channels(MAX_CH, 1, 4);
    ch_no_trl[0] = 1;
    send_frame(24'd30, 48'hABCDEF_012345, 16'h0005, 12'h0AC, 0, 24'h0, 0);
    wait_drain();
    check_state("overlong");

    do_clear();
    set_channels(2, 2, 1);
    send_frame(24'd40, 48'h1, 16'h0003, 12'h0AC, 0, 24'h123456, 4);
    send_frame(24'd41, 48'h2, 16'h0003, 12'h0AC, 0, 24'h0, 0);
    wait_drain();
    check_state("resync");

    do_clear();
    ev = 24'($urandom);
    for (int f = 0; f < 24; f++) begin
      for (int c = 0; c < 16; c++) begin
        ch_len[c] = $urandom_range(1, 5);
        ch_no_trl[c] = 0;
      end
      m = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      send_frame(ev, {24'($urandom), 24'($urandom)}, m, 12'h0AC, 0, 24'h0, 0);
      ev = ev + 24'd1;
      wait_drain();
    end
    check_state("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
